decode_queue_stage: RTL and testbench
=====================================

// Module: decode_queue_stage
// PURPOSE
//  Buffered RV32I decode stage between instruction fetch and dispatch/RS.
//  - Queues fetched {inst, pc} in a DEPTH-entry FIFO and decodes the head.
//  - Presents one registered decoded bundle per cycle on a valid/ready link.
//  - Adds over the plain decoder: illegal detection, rd=x0 squash to `NULL, precomputed pc+imm target, flush.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  PC_W    32  pc / target width
//  REG_W   6   register index width; architectural idx = {1'b0, 5-bit field}; `NULL marks unused
//  TRAP_ILLEGAL 1  1: illegal inst emitted with dec_illegal=1; 0: illegal inst dropped at dequeue
// PORTS
//  clk_in       in   1      clock, all state on posedge
//  rst_n_in     in   1      async active-low reset
//  rdy_in       in   1      global enable; 0 freezes all state
//  flush_in     in   1      mispredict/exception flush
//  if_valid     in   1      fetch offers instruction
//  if_inst      in   32     instruction word
//  if_pc        in   PC_W   its pc
//  if_ready     out  1      = !full & rdy_in & !flush_in
//  dec_valid    out  1      decoded bundle valid
//  dec_ready    in   1      dispatch accepts bundle
//  dec_op       out  6      operation code per operaType.v (`ADDI, `LW, `BEQ, ...)
//  dec_type     out  3      `IType/`ILoadType/`SType/`BType/`UType/`JType/`RType
//  dec_rs1/rs2/rd out REG_W  source/dest indices, `NULL when unused
//  dec_imm      out  32     sign/zero-extended immediate per format; 0 for R-type
//  dec_pc       out  PC_W   pc of instruction
//  dec_target   out  PC_W   dec_pc + dec_imm (valid for B/JAL/AUIPC; don't-care otherwise)
//  dec_illegal  out  1      unsupported opcode/func3/func7 combination
// BEHAVIOUR
//  Reset (async, rst_n_in=0): FIFO empty, wr/rd ptr=0, count=0, dec_valid=0, all dec_* = 0.
//  Enqueue on posedge when if_valid & if_ready; if_ready=0 when count==DEPTH (no pass-through at full).
//  Output register loads FIFO head when head present & (!dec_valid | dec_ready); head popped same edge.
//  dec_valid falls when dec_ready & nothing to load. Bundle holds stable while dec_valid & !dec_ready.
//  Latency: accepted at edge E0 -> dec_valid high after E1 (2-cycle min); throughput 1/cycle.
//  Simultaneous enq+deq: count unchanged, both pointers advance, wrap mod DEPTH.
//  Decode (combinational on head): field extraction identical to RV32I formats I/S/B/U/J.
//   - rs2=`NULL for I/Load/U/J; rd=`NULL for S/B; rs1=`NULL for U/J.
//   - rd field == 0 -> dec_rd=`NULL (no writeback); rs fields 0 stay 0 (x0 read).
//   - SRLI/SRAI and ADD/SUB/SRL/SRA: func7 not 0000000/0100000 -> illegal; SLLI func7!=0 -> illegal.
//   - Unknown opcode, Load func3 011/110/111, Store func3>=011, Branch func3 010/011 -> illegal.
//   - Illegal: dec_op=0, rs/rd=`NULL; TRAP_ILLEGAL=0 pops head without loading output.
//  dec_target = pc + imm, PC_W-bit wrap-around, no overflow flag.
//  flush_in=1 (highest priority): at next edge FIFO emptied, dec_valid=0; concurrent enq/deq discarded.
//  rdy_in=0: no state change, if_ready=0, outputs hold; flush_in also ignored while rdy_in=0.
//  Reset mid-operation: immediate return to reset state, in-flight entries lost.
// TESTING
//  1 Reset: rst_n_in=0 mid-stream -> dec_valid=0, if_ready=1 after release, count=0.
//  2 0x00500093 @pc 0x100 -> ADDI, IType, rd=1, rs1=0, rs2=`NULL, imm=5, 2 cycles after accept.
//  3 0x0020A423 (sw x2,8(x1)) -> SW, SType, rs1=1, rs2=2, rd=`NULL, imm=8; 0x123452B7 -> LUI, imm=0x12345000, rd=5.
//  4 dec_ready=0, push 5 insts DEPTH=4 -> if_ready low after 4 queued+1 in output; release -> in-order drain, no loss/dup.
//  5 BEQ imm=-16 @pc 0x0 -> dec_target=0xFFFFFFF0 (wrap); addi x0,x0,0 -> dec_rd=`NULL.
//  6 flush_in with full FIFO and if_valid=1 -> next cycle empty, dec_valid=0, flushed inst never emitted; 0xFFFFFFFF -> dec_illegal=1.

Source files
------------

// File: rtl/decode_queue_stage.sv
// decode_queue_stage
// Buffered RV32I decode stage: a DEPTH-entry {inst, pc} FIFO sits between
// fetch and dispatch. The FIFO head is decoded combinationally (p0) and
// captured into a registered bundle (p1) handed to dispatch on a
// valid/ready link. Also provides illegal-instruction detection, rd=x0
// squash, a precomputed pc+imm target, and flush.
module decode_queue_stage #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter int REG_W        = 6,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_valid,
    input  logic [31:0]       if_inst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [5:0]        dec_op,
    output logic [2:0]        dec_type,
    output logic [REG_W-1:0]  dec_rs1,
    output logic [REG_W-1:0]  dec_rs2,
    output logic [REG_W-1:0]  dec_rd,
    output logic [31:0]       dec_imm,
    output logic [PC_W-1:0]   dec_pc,
    output logic [PC_W-1:0]   dec_target,
    output logic              dec_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Index value meaning "no register": bit 5 set, outside the x0..x31 range
    localparam logic [REG_W-1:0] REG_NULL = REG_W'(32);

    // Bundle format codes
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_S     = 3'd3;
    localparam logic [2:0] T_B     = 3'd4;
    localparam logic [2:0] T_U     = 3'd5;
    localparam logic [2:0] T_J     = 3'd6;
    localparam logic [2:0] T_R     = 3'd7;

    // Operation codes (0 is reserved for illegal / nothing)
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Source index: x0 is a real read, so it is kept as index 0
    function automatic logic [REG_W-1:0] src_idx(input logic [4:0] field);
        return REG_W'(field);
    endfunction

    // Destination index: writes to x0 are squashed to "no writeback"
    function automatic logic [REG_W-1:0] dst_idx(input logic [4:0] field);
        return (field == 5'd0) ? REG_NULL : REG_W'(field);
    endfunction

    // FIFO storage and control
    logic [31:0]      r_fifo_inst [DEPTH];
    logic [PC_W-1:0]  r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_load;
    logic w_drop;
    logic w_out_free;

    // Head fields (p0: decode of FIFO head)
    logic [31:0]      w_head_inst_p0;
    logic [PC_W-1:0]  w_head_pc_p0;
    logic [6:0]       w_opcode_p0;
    logic [2:0]       w_f3_p0;
    logic [6:0]       w_f7_p0;
    logic [4:0]       w_rd_f_p0;
    logic [4:0]       w_rs1_f_p0;
    logic [4:0]       w_rs2_f_p0;
    logic signed [31:0] w_imm_i_p0;
    logic signed [31:0] w_imm_s_p0;
    logic signed [31:0] w_imm_b_p0;
    logic signed [31:0] w_imm_u_p0;
    logic signed [31:0] w_imm_j_p0;
    logic signed [31:0] w_imm_sh_p0;

    logic [5:0]         w_op_p0;
    logic [2:0]         w_type_p0;
    logic [REG_W-1:0]   w_rs1_p0;
    logic [REG_W-1:0]   w_rs2_p0;
    logic [REG_W-1:0]   w_rd_p0;
    logic signed [31:0] w_imm_p0;
    logic               w_illegal_p0;
    logic [PC_W-1:0]    w_target_p0;

    // Registered output bundle (p1)
    logic               r_vld_p1;
    logic [5:0]         r_op_p1;
    logic [2:0]         r_type_p1;
    logic [REG_W-1:0]   r_rs1_p1;
    logic [REG_W-1:0]   r_rs2_p1;
    logic [REG_W-1:0]   r_rd_p1;
    logic signed [31:0] r_imm_p1;
    logic [PC_W-1:0]    r_pc_p1;
    logic [PC_W-1:0]    r_target_p1;
    logic               r_illegal_p1;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign if_ready = !w_full && rdy_in && !flush_in;
    assign w_enq    = if_valid && if_ready;

    // An illegal head is discarded rather than presented when trapping is off
    assign w_drop     = w_illegal_p0 && (TRAP_ILLEGAL == 0);
    assign w_out_free = !r_vld_p1 || dec_ready;
    assign w_deq      = rdy_in && !flush_in && !w_empty && (w_out_free || w_drop);
    assign w_load     = w_deq && !w_drop;

    assign w_head_inst_p0 = r_fifo_inst[r_rd_ptr];
    assign w_head_pc_p0   = r_fifo_pc[r_rd_ptr];

    assign w_opcode_p0 = w_head_inst_p0[6:0];
    assign w_rd_f_p0   = w_head_inst_p0[11:7];
    assign w_f3_p0     = w_head_inst_p0[14:12];
    assign w_rs1_f_p0  = w_head_inst_p0[19:15];
    assign w_rs2_f_p0  = w_head_inst_p0[24:20];
    assign w_f7_p0     = w_head_inst_p0[31:25];

    assign w_imm_i_p0  = {{20{w_head_inst_p0[31]}}, w_head_inst_p0[31:20]};
    assign w_imm_s_p0  = {{20{w_head_inst_p0[31]}}, w_head_inst_p0[31:25], w_head_inst_p0[11:7]};
    assign w_imm_b_p0  = {{19{w_head_inst_p0[31]}}, w_head_inst_p0[31], w_head_inst_p0[7],
                          w_head_inst_p0[30:25], w_head_inst_p0[11:8], 1'b0};
    assign w_imm_u_p0  = {w_head_inst_p0[31:12], 12'b0};
    assign w_imm_j_p0  = {{11{w_head_inst_p0[31]}}, w_head_inst_p0[31], w_head_inst_p0[19:12],
                          w_head_inst_p0[20], w_head_inst_p0[30:21], 1'b0};
    assign w_imm_sh_p0 = {27'b0, w_head_inst_p0[24:20]};

    // Signed size cast sign-extends the immediate when PC_W exceeds 32 bits
    assign w_target_p0 = w_head_pc_p0 + PC_W'(w_imm_p0);

    // Combinational RV32I decode of the FIFO head
    always_comb begin
        w_op_p0      = '0;
        w_type_p0    = '0;
        w_rs1_p0     = REG_NULL;
        w_rs2_p0     = REG_NULL;
        w_rd_p0      = REG_NULL;
        w_imm_p0     = '0;
        w_illegal_p0 = 1'b0;
        case (w_opcode_p0)
            OPC_LUI, OPC_AUIPC: begin
                w_op_p0   = (w_opcode_p0 == OPC_LUI) ? OP_LUI : OP_AUIPC;
                w_type_p0 = T_U;
                w_rd_p0   = dst_idx(w_rd_f_p0);
                w_imm_p0  = w_imm_u_p0;
            end
            OPC_JAL: begin
                w_op_p0   = OP_JAL;
                w_type_p0 = T_J;
                w_rd_p0   = dst_idx(w_rd_f_p0);
                w_imm_p0  = w_imm_j_p0;
            end
            OPC_JALR: begin
                w_op_p0      = OP_JALR;
                w_type_p0    = T_I;
                w_rd_p0      = dst_idx(w_rd_f_p0);
                w_rs1_p0     = src_idx(w_rs1_f_p0);
                w_imm_p0     = w_imm_i_p0;
                w_illegal_p0 = (w_f3_p0 != 3'b000);
            end
            OPC_BRANCH: begin
                w_type_p0 = T_B;
                w_rs1_p0  = src_idx(w_rs1_f_p0);
                w_rs2_p0  = src_idx(w_rs2_f_p0);
                w_imm_p0  = w_imm_b_p0;
                case (w_f3_p0)
                    3'b000:  w_op_p0 = OP_BEQ;
                    3'b001:  w_op_p0 = OP_BNE;
                    3'b100:  w_op_p0 = OP_BLT;
                    3'b101:  w_op_p0 = OP_BGE;
                    3'b110:  w_op_p0 = OP_BLTU;
                    3'b111:  w_op_p0 = OP_BGEU;
                    default: w_illegal_p0 = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_type_p0 = T_LOAD;
                w_rd_p0   = dst_idx(w_rd_f_p0);
                w_rs1_p0  = src_idx(w_rs1_f_p0);
                w_imm_p0  = w_imm_i_p0;
                case (w_f3_p0)
                    3'b000:  w_op_p0 = OP_LB;
                    3'b001:  w_op_p0 = OP_LH;
                    3'b010:  w_op_p0 = OP_LW;
                    3'b100:  w_op_p0 = OP_LBU;
                    3'b101:  w_op_p0 = OP_LHU;
                    default: w_illegal_p0 = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_type_p0 = T_S;
                w_rs1_p0  = src_idx(w_rs1_f_p0);
                w_rs2_p0  = src_idx(w_rs2_f_p0);
                w_imm_p0  = w_imm_s_p0;
                case (w_f3_p0)
                    3'b000:  w_op_p0 = OP_SB;
                    3'b001:  w_op_p0 = OP_SH;
                    3'b010:  w_op_p0 = OP_SW;
                    default: w_illegal_p0 = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                w_type_p0 = T_I;
                w_rd_p0   = dst_idx(w_rd_f_p0);
                w_rs1_p0  = src_idx(w_rs1_f_p0);
                w_imm_p0  = w_imm_i_p0;
                case (w_f3_p0)
                    3'b000: w_op_p0 = OP_ADDI;
                    3'b010: w_op_p0 = OP_SLTI;
                    3'b011: w_op_p0 = OP_SLTIU;
                    3'b100: w_op_p0 = OP_XORI;
                    3'b110: w_op_p0 = OP_ORI;
                    3'b111: w_op_p0 = OP_ANDI;
                    3'b001: begin
                        w_op_p0      = OP_SLLI;
                        w_imm_p0     = w_imm_sh_p0;
                        w_illegal_p0 = (w_f7_p0 != F7_ZERO);
                    end
                    default: begin
                        w_imm_p0 = w_imm_sh_p0;
                        if (w_f7_p0 == F7_ZERO)     w_op_p0 = OP_SRLI;
                        else if (w_f7_p0 == F7_ALT) w_op_p0 = OP_SRAI;
                        else                        w_illegal_p0 = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_type_p0 = T_R;
                w_rd_p0   = dst_idx(w_rd_f_p0);
                w_rs1_p0  = src_idx(w_rs1_f_p0);
                w_rs2_p0  = src_idx(w_rs2_f_p0);
                case (w_f3_p0)
                    3'b000: begin
                        if (w_f7_p0 == F7_ZERO)     w_op_p0 = OP_ADD;
                        else if (w_f7_p0 == F7_ALT) w_op_p0 = OP_SUB;
                        else                        w_illegal_p0 = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7_p0 == F7_ZERO)     w_op_p0 = OP_SRL;
                        else if (w_f7_p0 == F7_ALT) w_op_p0 = OP_SRA;
                        else                        w_illegal_p0 = 1'b1;
                    end
                    default: begin
                        case (w_f3_p0)
                            3'b001:  w_op_p0 = OP_SLL;
                            3'b010:  w_op_p0 = OP_SLT;
                            3'b011:  w_op_p0 = OP_SLTU;
                            3'b100:  w_op_p0 = OP_XOR;
                            3'b110:  w_op_p0 = OP_OR;
                            default: w_op_p0 = OP_AND;
                        endcase
                        w_illegal_p0 = (w_f7_p0 != F7_ZERO);
                    end
                endcase
            end
            default: w_illegal_p0 = 1'b1;
        endcase
        // Illegal instructions carry no operation and no register usage
        if (w_illegal_p0) begin
            w_op_p0   = '0;
            w_type_p0 = '0;
            w_rs1_p0  = REG_NULL;
            w_rs2_p0  = REG_NULL;
            w_rd_p0   = REG_NULL;
            w_imm_p0  = '0;
        end
    end

    // FIFO pointers and occupancy; flush empties, rdy_in=0 freezes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO payload write; contents are meaningless outside the occupied window
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_fifo_inst[r_wr_ptr] <= if_inst;
            r_fifo_pc[r_wr_ptr]   <= if_pc;
        end
    end

    // ---- p0 -> p1: capture decoded head into the output bundle ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld_p1     <= 1'b0;
            r_op_p1      <= '0;
            r_type_p1    <= '0;
            r_rs1_p1     <= '0;
            r_rs2_p1     <= '0;
            r_rd_p1      <= '0;
            r_imm_p1     <= '0;
            r_pc_p1      <= '0;
            r_target_p1  <= '0;
            r_illegal_p1 <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_vld_p1 <= 1'b0;
            end else if (w_load) begin
                r_vld_p1     <= 1'b1;
                r_op_p1      <= w_op_p0;
                r_type_p1    <= w_type_p0;
                r_rs1_p1     <= w_rs1_p0;
                r_rs2_p1     <= w_rs2_p0;
                r_rd_p1      <= w_rd_p0;
                r_imm_p1     <= w_imm_p0;
                r_pc_p1      <= w_head_pc_p0;
                r_target_p1  <= w_target_p0;
                r_illegal_p1 <= w_illegal_p0;
            end else if (dec_ready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign dec_valid   = r_vld_p1;
    assign dec_op      = r_op_p1;
    assign dec_type    = r_type_p1;
    assign dec_rs1     = r_rs1_p1;
    assign dec_rs2     = r_rs2_p1;
    assign dec_rd      = r_rd_p1;
    assign dec_imm     = r_imm_p1;
    assign dec_pc      = r_pc_p1;
    assign dec_target  = r_target_p1;
    assign dec_illegal = r_illegal_p1;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed testbench for decode_queue_stage (default parameters).
module tb_decode_queue_stage;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [5:0]  dec_op;
    logic [2:0]  dec_type;
    logic [5:0]  dec_rs1;
    logic [5:0]  dec_rs2;
    logic [5:0]  dec_rd;
    logic [31:0] dec_imm;
    logic [31:0] dec_pc;
    logic [31:0] dec_target;
    logic        dec_illegal;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [5:0] RNULL   = 6'h20;
    localparam logic [5:0] OP_LUI  = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd18;
    localparam logic [5:0] OP_ADDI = 6'd19;
    localparam logic [5:0] OP_SUB  = 6'd29;
    localparam logic [2:0] T_I = 3'd1, T_S = 3'd3, T_B = 3'd4, T_U = 3'd5, T_R = 3'd7;

    decode_queue_stage #(.DEPTH(4), .PC_W(32), .REG_W(6), .TRAP_ILLEGAL(1)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_type(dec_type),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_imm(dec_imm),
        .dec_pc(dec_pc), .dec_target(dec_target), .dec_illegal(dec_illegal)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic [5:0] op, input logic [2:0] ty,
                              input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                              input logic [31:0] imm, input logic [31:0] pc);
        chk({tag, ".valid"}, dec_valid, 1);
        chk({tag, ".op"}, dec_op, op);
        chk({tag, ".type"}, dec_type, ty);
        chk({tag, ".rs1"}, dec_rs1, rs1);
        chk({tag, ".rs2"}, dec_rs2, rs2);
        chk({tag, ".rd"}, dec_rd, rd);
        chk({tag, ".imm"}, dec_imm, imm);
        chk({tag, ".pc"}, dec_pc, pc);
        chk({tag, ".illegal"}, dec_illegal, 0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    initial begin
        rst_n_in  = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        dec_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("reset.dec_valid", dec_valid, 0);
        chk("reset.dec_op", dec_op, 0);
        chk("reset.dec_rd", dec_rd, 0);
        chk("reset.if_ready", if_ready, 1);
        rst_n_in = 1'b1;
        tick();

        // addi x1,x0,5 @0x100 : visible two edges after acceptance
        drive(1'b1, 32'h00500093, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1 chk("addi.latency1", dec_valid, 0);
        tick();
        chk_bundle("addi", OP_ADDI, T_I, 6'd0, RNULL, 6'd1, 32'd5, 32'h100);
        tick();
        chk("addi.drop_valid", dec_valid, 0);

        // sw x2,8(x1) then lui x5,0x12345 back to back
        drive(1'b1, 32'h0020A423, 32'h104);
        tick();
        drive(1'b1, 32'h123452B7, 32'h108);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("sw", OP_SW, T_S, 6'd1, 6'd2, RNULL, 32'd8, 32'h104);
        tick();
        chk_bundle("lui", OP_LUI, T_U, RNULL, RNULL, 6'd5, 32'h12345000, 32'h108);
        tick();
        chk("lui.drop_valid", dec_valid, 0);

        // Back-pressure: 4 queued + 1 in output, then in-order drain
        dec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, (32'(i) << 20) | (32'(i) << 7) | 32'h13, 32'h400 + 32'(4 * i));
            #1 chk("fill.if_ready", if_ready, 1);
            tick();
        end
        drive(1'b1, 32'h00600313, 32'h418);
        #1 chk("full.if_ready", if_ready, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("hold1", OP_ADDI, T_I, 6'd0, RNULL, 6'd1, 32'd1, 32'h404);
        dec_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("drain.valid", dec_valid, 1);
            chk("drain.rd", dec_rd, 6'(i));
            chk("drain.imm", dec_imm, 32'(i));
            chk("drain.pc", dec_pc, 32'h400 + 32'(4 * i));
        end
        tick();
        chk("drain.empty", dec_valid, 0);

        // beq x1,x2,-16 @0 wraps target; addi x0,x0,0 squashes rd
        drive(1'b1, 32'hFE2088E3, 32'h0);
        tick();
        drive(1'b1, 32'h00000013, 32'h4);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("beq", OP_BEQ, T_B, 6'd1, 6'd2, RNULL, 32'hFFFFFFF0, 32'h0);
        chk("beq.target", dec_target, 32'hFFFFFFF0);
        tick();
        chk_bundle("nop", OP_ADDI, T_I, 6'd0, RNULL, RNULL, 32'd0, 32'h4);
        tick();

        // sub x3,x1,x2 legal; sll with func7=0100000 illegal
        drive(1'b1, 32'h402081B3, 32'h20);
        tick();
        drive(1'b1, 32'h40001033, 32'h24);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("sub", OP_SUB, T_R, 6'd1, 6'd2, 6'd3, 32'd0, 32'h20);
        tick();
        chk("sllalt.illegal", dec_illegal, 1);
        chk("sllalt.op", dec_op, 0);
        tick();

        // rdy_in=0 freezes everything
        drive(1'b1, 32'h00900493, 32'h30);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        rdy_in = 1'b0;
        #1 chk("frz.if_ready", if_ready, 0);
        tick();
        tick();
        chk("frz.valid", dec_valid, 0);
        rdy_in = 1'b1;
        tick();
        chk("frz.release_valid", dec_valid, 1);
        chk("frz.release_rd", dec_rd, 6'd9);
        tick();

        // Flush with a full FIFO and fetch still offering
        dec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, (32'(i) << 20) | (32'(i) << 7) | 32'h13, 32'h200 + 32'(4 * i));
            tick();
        end
        drive(1'b1, 32'h00700393, 32'h300);
        flush_in = 1'b1;
        #1 chk("flush.if_ready", if_ready, 0);
        tick();
        flush_in = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush.valid", dec_valid, 0);
        #1 chk("flush.if_ready_after", if_ready, 1);
        dec_ready = 1'b1;
        tick();
        chk("flush.no_emit1", dec_valid, 0);
        tick();
        chk("flush.no_emit2", dec_valid, 0);

        // All-ones word is an unknown opcode
        drive(1'b1, 32'hFFFFFFFF, 32'h300);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("ill.valid", dec_valid, 1);
        chk("ill.illegal", dec_illegal, 1);
        chk("ill.op", dec_op, 0);
        chk("ill.rd", dec_rd, RNULL);
        chk("ill.rs1", dec_rs1, RNULL);
        chk("ill.pc", dec_pc, 32'h300);
        tick();

        // Asynchronous reset in the middle of traffic
        dec_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h500);
        tick();
        drive(1'b1, 32'h00600113, 32'h504);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("mid.valid_before", dec_valid, 1);
        #2 rst_n_in = 1'b0;
        #1 chk("mid.valid_async", dec_valid, 0);
        chk("mid.op_async", dec_op, 0);
        tick();
        #2 rst_n_in = 1'b1;
        tick();
        chk("mid.if_ready", if_ready, 1);
        dec_ready = 1'b1;
        tick();
        chk("mid.empty1", dec_valid, 0);
        tick();
        chk("mid.empty2", dec_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
